// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the CPLD UART responder.
//   tx_state_t / rx_state_t : transmitter and receiver FSM states
//   DATA_BITS               : payload bits per frame (8N1)
//   IDLE_LEVEL / START_LEVEL: serial line levels
package uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core
// Serial receiver: synchronizer on the line input, RX FSM and bit timer.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   rxd      : serial line input (idle high), asynchronous to clk
//   rx_byte  : last assembled byte, valid while rx_valid is high
//   rx_valid : one-cycle pulse when a byte with a good stop bit completes
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,  // >= 4
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_TICK = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_prev_reg;
  logic                   rx_s;
  rx_state_t              state_reg, state_next;
  logic [TW-1:0]          timer_reg;
  logic [BW-1:0]          bit_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   valid_reg;
  logic                   timer_hit;

  assign rx_s = sync_reg[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= R_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      R_IDLE:  if (rx_prev_reg && !rx_s) state_next = R_START;
      // Mid-start-bit check rejects glitches shorter than half a bit.
      R_START: if (timer_hit) state_next = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (timer_hit && bit_reg == LAST_BIT) state_next = R_STOP;
      R_STOP:  if (timer_hit) state_next = R_IDLE;
      default: state_next = R_IDLE;
    endcase
  end

  // Output/strobe logic: the start bit waits half a bit so every later
  // sample lands in the middle of its bit cell.
  always_comb begin
    timer_hit = 1'b0;
    case (state_reg)
      R_START:        timer_hit = (timer_reg == HALF_TICK);
      R_DATA, R_STOP: timer_hit = (timer_reg == LAST_TICK);
      default:        timer_hit = 1'b0;
    endcase
  end

  // Synchronizer and datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg    <= '1;
      rx_prev_reg <= IDLE_LEVEL;
      timer_reg   <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      valid_reg   <= 1'b0;
    end else begin
      sync_reg[0] <= rxd;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      rx_prev_reg <= rx_s;

      if (state_reg == R_IDLE || timer_hit) timer_reg <= '0;
      else                                  timer_reg <= timer_reg + 1'b1;

      if (state_reg != R_DATA) bit_reg <= '0;
      else if (timer_hit)      bit_reg <= bit_reg + 1'b1;

      if (state_reg == R_DATA && timer_hit) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};

      // A low stop bit is a framing error: no pulse, byte discarded.
      valid_reg <= (state_reg == R_STOP) && timer_hit && (rx_s == IDLE_LEVEL);
    end
  end

  // shift_reg does not move until the next frame's data bits, so it is
  // still the completed byte while valid_reg pulses.
  assign rx_byte  = shift_reg;
  assign rx_valid = valid_reg;

endmodule

// File: rtl/uart_cpld_responder.sv
// uart_cpld_responder
// Device-side CPLD UART: host bus writes go out on txd, bytes on rxd land
// in the receive buffer, 8N1 LSB first.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   wrn, rdn       : host write/read strobes, active-low, asynchronous
//   bus_data       : shared host bus; driven with RBR only while rdn is low
//   tbre, tsre     : transmit holding / shift register empty
//   data_ready     : received byte waiting in RBR
//   txd, rxd       : serial lines, idle high
// Build option: define UART_LOOPBACK_EN to feed txd back into the receiver
// internally (rxd is then ignored).
module uart_cpld_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,  // 50 MHz / 115200, >= 4
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wrn,
  input  logic                 rdn,
  inout  wire  [DATA_BITS-1:0] bus_data,
  output logic                 tbre,
  output logic                 tsre,
  output logic                 data_ready,
  output logic                 txd,
  input  logic                 rxd
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] wrn_sync_reg, rdn_sync_reg;
  logic [DATA_BITS-1:0]   data_pipe_reg [SYNC_STAGES];
  logic                   wrn_prev_reg, rdn_prev_reg;
  logic                   wr_fall, rd_rise;

  logic [DATA_BITS-1:0]   thr_reg, tsr_reg, rbr_reg;
  logic                   tbre_reg, tsre_reg, ready_reg;
  tx_state_t              tx_state_reg, tx_state_next;
  logic [TW-1:0]          tx_timer_reg;
  logic [BW-1:0]          tx_bit_reg;
  logic                   tx_hit, tsr_load;

  logic                   rx_src;
  logic [DATA_BITS-1:0]   rx_byte;
  logic                   rx_valid;

  // The bus is driven straight from raw rdn so read data is there within
  // the host's strobe, without waiting for the synchronizer.
  assign bus_data = rdn ? {DATA_BITS{1'bz}} : rbr_reg;

  // Strobe synchronizers; bus data goes through an equal-depth pipe so the
  // sample that lines up with the synchronized wrn edge is used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrn_sync_reg <= '1;
      rdn_sync_reg <= '1;
      wrn_prev_reg <= 1'b1;
      rdn_prev_reg <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) data_pipe_reg[i] <= '0;
    end else begin
      wrn_sync_reg[0]  <= wrn;
      rdn_sync_reg[0]  <= rdn;
      data_pipe_reg[0] <= bus_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        wrn_sync_reg[i]  <= wrn_sync_reg[i-1];
        rdn_sync_reg[i]  <= rdn_sync_reg[i-1];
        data_pipe_reg[i] <= data_pipe_reg[i-1];
      end
      wrn_prev_reg <= wrn_sync_reg[SYNC_STAGES-1];
      rdn_prev_reg <= rdn_sync_reg[SYNC_STAGES-1];
    end
  end

  assign wr_fall = wrn_prev_reg & ~wrn_sync_reg[SYNC_STAGES-1];
  assign rd_rise = ~rdn_prev_reg & rdn_sync_reg[SYNC_STAGES-1];

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state_reg <= T_IDLE;
    else      tx_state_reg <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    case (tx_state_reg)
      T_IDLE:  if (!tbre_reg) tx_state_next = T_START;
      T_START: if (tx_hit) tx_state_next = T_DATA;
      T_DATA:  if (tx_hit && tx_bit_reg == LAST_BIT) tx_state_next = T_STOP;
      // A queued byte starts right after the stop bit, no idle gap.
      T_STOP:  if (tx_hit) tx_state_next = tbre_reg ? T_IDLE : T_START;
      default: tx_state_next = T_IDLE;
    endcase
  end

  // txd is decoded from state so an asynchronous reset returns the line
  // high at once, even mid-frame. Data bits come from TSR bit 0 as it shifts.
  always_comb begin
    txd = IDLE_LEVEL;
    case (tx_state_reg)
      T_START: txd = START_LEVEL;
      T_DATA:  txd = tsr_reg[0];
      default: txd = IDLE_LEVEL;
    endcase
  end

  assign tx_hit   = (tx_state_reg != T_IDLE) && (tx_timer_reg == LAST_TICK);
  assign tsr_load = !tbre_reg &&
                    ((tx_state_reg == T_IDLE) || (tx_state_reg == T_STOP && tx_hit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thr_reg      <= '0;
      tsr_reg      <= '0;
      tbre_reg     <= 1'b1;
      tsre_reg     <= 1'b1;
      tx_timer_reg <= '0;
      tx_bit_reg   <= '0;
    end else begin
      // tsr_load needs tbre=0 and a capture needs tbre=1, so they never
      // collide; writes arriving while THR is full are dropped.
      if (tsr_load) begin
        tbre_reg <= 1'b1;
      end else if (wr_fall && tbre_reg) begin
        thr_reg  <= data_pipe_reg[SYNC_STAGES-1];
        tbre_reg <= 1'b0;
      end

      if (tsr_load)                              tsr_reg <= thr_reg;
      else if (tx_state_reg == T_DATA && tx_hit) tsr_reg <= {1'b0, tsr_reg[DATA_BITS-1:1]};

      if (tsr_load)                              tsre_reg <= 1'b0;
      else if (tx_state_reg == T_STOP && tx_hit) tsre_reg <= 1'b1;

      if (tx_state_reg == T_IDLE || tx_hit) tx_timer_reg <= '0;
      else                                  tx_timer_reg <= tx_timer_reg + 1'b1;

      if (tx_state_reg != T_DATA) tx_bit_reg <= '0;
      else if (tx_hit)            tx_bit_reg <= tx_bit_reg + 1'b1;
    end
  end

  // ---------------- RX ----------------
`ifdef UART_LOOPBACK_EN
  assign rx_src = txd;
`else
  assign rx_src = rxd;
`endif

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rx_src),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid)
  );

  // A new byte always wins over the end-of-read clear (overrun keeps
  // data_ready set and overwrites RBR).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbr_reg   <= '0;
      ready_reg <= 1'b0;
    end else if (rx_valid) begin
      rbr_reg   <= rx_byte;
      ready_reg <= 1'b1;
    end else if (rd_rise) begin
      ready_reg <= 1'b0;
    end
  end

  assign tbre       = tbre_reg;
  assign tsre       = tsre_reg;
  assign data_ready = ready_reg;

endmodule

// File: tb/tb_uart_cpld_responder.sv
module tb_uart_cpld_responder;

  localparam int CPB = 4;
  localparam int SS  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wrn = 1'b1;
  logic       rdn = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] tb_drv = 8'h00;
  logic       tb_drv_en = 1'b0;
  wire  [7:0] bus_data;
  logic       tbre, tsre, data_ready, txd;

  int checks = 0;
  int failures = 0;

  // Reference model of the receive side: what RBR holds and whether a byte
  // is pending, updated from the frames and reads the bench performs.
  logic       dr_m = 1'b0;
  logic [7:0] rbr_m = 8'h00;
  logic       saw_tbre0;

  assign bus_data = tb_drv_en ? tb_drv : 8'bz;

  always #5 clk = ~clk;

  uart_cpld_responder #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wrn        (wrn),
    .rdn        (rdn),
    .bus_data   (bus_data),
    .tbre       (tbre),
    .tsre       (tsre),
    .data_ready (data_ready),
    .txd        (txd),
    .rxd        (rxd)
  );

  // Serial level of bit position bp of an 8N1 frame (0=start, 9=stop).
  function automatic logic exp_level(input logic [7:0] b, input int bp);
    if (bp == 0) return 1'b0;
    if (bp == 9) return 1'b1;
    return b[bp-1];
  endfunction

  task automatic host_write(input logic [7:0] d);
    @(posedge clk); #1;
    tb_drv = d; tb_drv_en = 1'b1; wrn = 1'b0;
    repeat (4) @(posedge clk);
    #1 wrn = 1'b1;
    @(posedge clk); #1 tb_drv_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic host_read(output logic [7:0] got);
    @(posedge clk); #1 rdn = 1'b0;
    @(negedge clk); got = bus_data;
    @(posedge clk); #1 rdn = 1'b1;
    repeat (SS + 3) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    for (int bp = 0; bp < 10; bp++) begin
      rxd = (bp == 9) ? stop_bit : exp_level(b, bp);
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    if (stop_bit) begin
      dr_m = 1'b1;
      rbr_m = b;
    end
  endtask

  // Wait for a start bit, then check every cycle of nframes frames plus
  // idle_after cycles of idle line.
  task automatic tx_capture(input int nframes, input logic [7:0] b0, input logic [7:0] b1,
                            input int idle_after, input string name);
    int t;
    int errs;
    logic [9:0] got;
    logic [9:0] want;
    logic [7:0] b;
    t = 0;
    @(negedge clk);
    while (txd !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 300) begin
      failures++;
      $display("FAIL %s_start: no start bit seen, txd=%b required 0", name, txd);
      return;
    end
    checks++;
    if (tsre !== 1'b0) begin
      failures++;
      $display("FAIL %s_tsre_busy: tsre=%b required 0", name, tsre);
    end
    for (int f = 0; f < nframes; f++) begin
      b = (f == 0) ? b0 : b1;
      want = {1'b1, b, 1'b0};
      got = '0;
      errs = 0;
      for (int k = 0; k < 10 * CPB; k++) begin
        if (k > 0 || f > 0) @(negedge clk);
        if (k % CPB == CPB / 2) got[k / CPB] = txd;
        if (txd !== exp_level(b, k / CPB)) errs++;
      end
      checks++;
      if (errs != 0) begin
        failures++;
        $display("FAIL %s_frame%0d: got=%b required=%b bad_cycles=%0d", name, f, got, want, errs);
      end
    end
    if (idle_after > 0) begin
      errs = 0;
      for (int k = 0; k < idle_after; k++) begin
        @(negedge clk);
        if (txd !== 1'b1) errs++;
      end
      checks++;
      if (errs != 0) begin
        failures++;
        $display("FAIL %s_idle: txd low for %0d cycles, required 0", name, errs);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++; if (txd !== 1'b1)        begin failures++; $display("FAIL reset_txd: got=%b required=1", txd); end
    checks++; if (tbre !== 1'b1)       begin failures++; $display("FAIL reset_tbre: got=%b required=1", tbre); end
    checks++; if (tsre !== 1'b1)       begin failures++; $display("FAIL reset_tsre: got=%b required=1", tsre); end
    checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL reset_data_ready: got=%b required=0", data_ready); end
    $display("reset: txd=%b tbre=%b tsre=%b data_ready=%b", txd, tbre, tsre, data_ready);
  endtask

  task automatic test_tx_single();
    saw_tbre0 = 1'b0;
    fork
      host_write(8'hA5);
      tx_capture(1, 8'hA5, 8'h00, 0, "tx_a5");
      begin
        repeat (15) begin
          @(negedge clk);
          if (tbre === 1'b0) saw_tbre0 = 1'b1;
        end
      end
    join
    checks++;
    if (saw_tbre0 !== 1'b1) begin failures++; $display("FAIL tx_a5_tbre_pulse: tbre_low_seen=%b required=1", saw_tbre0); end
    repeat (2) @(negedge clk);
    checks++;
    if (tsre !== 1'b1 || tbre !== 1'b1) begin
      failures++;
      $display("FAIL tx_a5_done: tsre=%b tbre=%b required 1 1", tsre, tbre);
    end
    $display("tx single: byte=a5 tsre=%b", tsre);
  endtask

  task automatic test_back_to_back();
    fork
      begin
        host_write(8'h3C);
        host_write(8'hC3);
        repeat (2) @(posedge clk);
        host_write(8'h77);   // THR full here: must be dropped
      end
      tx_capture(2, 8'h3C, 8'hC3, 10 * CPB, "tx_b2b");
    join
    @(negedge clk);
    checks++;
    if (tsre !== 1'b1 || tbre !== 1'b1) begin
      failures++;
      $display("FAIL tx_b2b_done: tsre=%b tbre=%b required 1 1", tsre, tbre);
    end
    $display("tx back-to-back: 3c,c3 contiguous, 77 dropped");
  endtask

  task automatic test_rx_basic();
    logic [7:0] got;
    send_rx(8'h5A, 1'b1);
    @(negedge clk);
    checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL rx_5a_ready: got=%b required=1", data_ready); end
    host_read(got);
    dr_m = 1'b0;
    checks++; if (got !== 8'h5A) begin failures++; $display("FAIL rx_5a_bus: got=%h required=5a", got); end
    @(negedge clk);
    checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL rx_5a_clear: got=%b required=0", data_ready); end
    // RBR is non-zero now: with rdn high the DUT must leave the bus alone.
    tb_drv = 8'h00; tb_drv_en = 1'b1;
    @(negedge clk);
    checks++; if (bus_data !== 8'h00) begin failures++; $display("FAIL bus_released: got=%h required=00", bus_data); end
    tb_drv_en = 1'b0;
    // Overrun: second byte replaces the unread first one.
    send_rx(8'h81, 1'b1);
    send_rx(8'h1E, 1'b1);
    host_read(got);
    dr_m = 1'b0;
    checks++; if (got !== 8'h1E) begin failures++; $display("FAIL rx_overrun: got=%h required=1e", got); end
    $display("rx: 5a read back, overrun read=%h", got);
  endtask

  task automatic test_rx_framing();
    logic [7:0] b;
    logic [7:0] got;
    b = 8'($urandom);
    send_rx(b, 1'b0);
    @(negedge clk);
    checks++; if (data_ready !== dr_m) begin failures++; $display("FAIL rx_framing: data_ready=%b required=%b", data_ready, dr_m); end
    @(posedge clk); #1 rxd = 1'b0;
    @(posedge clk); #1 rxd = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checks++; if (data_ready !== dr_m) begin failures++; $display("FAIL rx_glitch: data_ready=%b required=%b", data_ready, dr_m); end
    b = 8'($urandom);
    send_rx(b, 1'b1);
    host_read(got);
    dr_m = 1'b0;
    checks++; if (got !== rbr_m) begin failures++; $display("FAIL rx_after_glitch: got=%h required=%h", got, rbr_m); end
    $display("rx framing/glitch: following byte=%h", got);
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] b;
    logic [7:0] got;
    fork
      host_write(8'hA5);
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (txd !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        repeat (4 * CPB + 1) @(negedge clk);   // inside data bit 3 of A5 (a 0)
        checks++;
        if (txd !== 1'b0) begin failures++; $display("FAIL rst_mid_bit3: txd=%b required=0", txd); end
      end
    join
    #2 rst = 1'b0;
    #1;
    checks++; if (txd !== 1'b1)        begin failures++; $display("FAIL rst_mid_txd: got=%b required=1", txd); end
    checks++; if (tsre !== 1'b1)       begin failures++; $display("FAIL rst_mid_tsre: got=%b required=1", tsre); end
    checks++; if (tbre !== 1'b1)       begin failures++; $display("FAIL rst_mid_tbre: got=%b required=1", tbre); end
    @(negedge clk);
    rst = 1'b1;
    dr_m = 1'b0;
    rbr_m = 8'h00;
    repeat (3) @(posedge clk);
    host_read(got);
    checks++; if (got !== rbr_m) begin failures++; $display("FAIL rst_rbr_cleared: got=%h required=%h", got, rbr_m); end
    b = 8'($urandom);
    fork
      host_write(b);
      tx_capture(1, b, 8'h00, 0, "tx_after_rst");
    join
    $display("reset mid-frame: next byte=%h", b);
  endtask

  task automatic test_random();
    int op;
    logic [7:0] b;
    logic [7:0] got;
    for (int i = 0; i < 14; i++) begin
      op = $urandom_range(0, 3);
      b = 8'($urandom);
      case (op)
        0: begin
          fork
            host_write(b);
            tx_capture(1, b, 8'h00, 0, "rand_tx");
          join
          repeat (3) @(posedge clk);
          $display("rand %0d: tx byte=%h", i, b);
        end
        1: begin
          send_rx(b, 1'b1);
          $display("rand %0d: rx good byte=%h", i, b);
        end
        2: begin
          send_rx(b, 1'b0);
          $display("rand %0d: rx framing-error byte=%h", i, b);
        end
        default: begin
          host_read(got);
          dr_m = 1'b0;
          checks++;
          if (got !== rbr_m) begin failures++; $display("FAIL rand_read: got=%h required=%h", got, rbr_m); end
          $display("rand %0d: read=%h", i, got);
        end
      endcase
      @(negedge clk);
      checks++;
      if (data_ready !== dr_m) begin failures++; $display("FAIL rand_ready: got=%b required=%b", data_ready, dr_m); end
    end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_basic();
    test_rx_framing();
    test_reset_mid_tx();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cpld_responder.md
Name: uart_cpld_responder

Overview:
- Device-side model/implementation of the CPLD UART that the host-side serial connection drives.
- Host writes with active-low wrn and reads with active-low rdn over a shared 8-bit bus; the block reports tbre/tsre/data_ready back to the host.
- Serializes host bytes onto txd and deserializes rxd into a receive buffer, 8N1, LSB first.
- Sits between the host bus pins and the physical UART lines; used both in the board image and as the bench partner for host-side serial logic.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); minimum 4.
- SYNC_STAGES, 2, flip-flop stages on the wrn, rdn and rxd synchronizers.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset; one clock, async active-low, as decided.
- wrn  input  1  host write strobe, active-low.
- rdn  input  1  host read strobe, active-low.
- bus_data  inout  8  shared host data bus.
- tbre  output  1  transmit holding register empty.
- tsre  output  1  transmit shift register empty.
- data_ready  output  1  received byte available.
- txd  output  1  serial transmit line, idle high.
- rxd  input  1  serial receive line, idle high.

Behaviour:
- Reset (async, rst=0):
  - txd=1, tbre=1, tsre=1, data_ready=0, bus_data high-Z.
  - THR, TSR and RBR cleared to 0; both FSMs return to IDLE.
  - Reset mid-frame aborts the frame immediately; txd goes to 1 asynchronously.
- Bus drive:
  - bus_data = RBR while raw rdn=0, combinational.
  - High-Z otherwise; never driven while rdn=1.
- Write capture:
  - wrn passes through the SYNC_STAGES synchronizer.
  - bus_data is sampled through an equal-depth pipeline.
  - On the synchronized falling edge of wrn, THR is loaded from the aligned sample and tbre=0 the next cycle.
  - Host must hold wrn low with data stable for at least SYNC_STAGES+1 cycles.
  - A write while tbre=0 is dropped; THR is unchanged.
- TX FSM states: T_IDLE, T_START, T_DATA, T_STOP.
  - T_IDLE with tbre=0: TSR<=THR, tbre=1, tsre=0, go to T_START (1 cycle).
  - T_START: txd=0 for CLKS_PER_BIT cycles.
  - T_DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; bit counter 0..7.
  - T_STOP: txd=1 for CLKS_PER_BIT cycles.
  - Leaving T_STOP: if tbre=0, reload TSR in the same cycle (back-to-back, tsre stays 0); else tsre=1, go to T_IDLE.
  - A write accepted during a frame fills THR, so a second byte can be queued.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP; input is synchronized rxd.
  - R_IDLE: 1->0 transition on rxd enters R_START.
  - R_START: sample at CLKS_PER_BIT/2. If rxd=1, false start, back to R_IDLE; else go to R_DATA.
  - R_DATA: 8 samples, each CLKS_PER_BIT apart, shifted in LSB first.
  - R_STOP: sample once. If 1, RBR<=byte and data_ready=1. If 0, framing error: byte discarded, data_ready unchanged.
  - Either way, return to R_IDLE.
- data_ready:
  - Cleared on the synchronized rising edge of rdn (end of host read).
  - A new byte arriving while data_ready=1 overwrites RBR (overrun); data_ready stays 1.
  - Byte completion and rdn rising edge in the same cycle: new byte wins, data_ready stays 1.
- Counters:
  - Bit timer width $clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1 and wrapping.
  - One frame = 10*CLKS_PER_BIT cycles.

Optional Feature:
- UART_LOOPBACK_EN
  - Defined: the RX synchronizer input is txd internally and the rxd port is ignored. Every transmitted byte reappears in RBR about 10*CLKS_PER_BIT+SYNC_STAGES cycles after T_START.
  - Undefined: RX uses the rxd port only.

Decomposition:
- Package uart_pkg:
  - tx_state_t and rx_state_t enums.
  - DATA_BITS=8.
  - IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
- Sub-module uart_rx_core:
  - Contains the rxd synchronizer, RX FSM and bit timer.
  - Outputs a byte plus a one-cycle valid pulse; the top level owns RBR and data_ready.

Test Plan (CLKS_PER_BIT=4):
- Reset then idle 50 cycles -> txd=1, tbre=1, tsre=1, data_ready=0, bus_data=Z.
- Write 0xA5 (wrn low 4 cycles) -> tbre briefly 0; txd = 0,1,0,1,0,0,1,0,1,1 at 4 cycles/bit; tsre=1 after the stop bit.
- Write 0x3C then 0xC3 back-to-back -> both frames contiguous with no idle gap; a third write while tbre=0 is dropped.
- Drive rxd frame for 0x5A -> data_ready=1; rdn low shows 0x5A on bus_data; data_ready=0 after rdn rises.
- rxd frame with stop bit 0, then a 1-cycle low glitch -> data_ready stays 0, RX back in R_IDLE.
- Assert rst mid-TX frame at bit 3 -> txd=1 and tsre=1 immediately; the next write transmits a full frame.
